// File: rtl/mmio_pwm.sv
// mmio_pwm: memory-mapped PWM with double-buffered duty/period.
// Bus slave on mem_valid/addr/wdata/wstrb -> mem_rdata/ready.
// Ports: clk, rst_n (sync, active-low); mem_* CPU bus slave;
//        pwm_out registered PWM; period_start one-cycle wrap pulse.
module mmio_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          CNT_W     = 16,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        pwm_out,
  output logic        period_start
);

  logic [CNT_W-1:0]   duty_q;
  logic [CNT_W-1:0]   period_q;
  logic               en_q;
  logic [PRESC_W-1:0] presc_q;

  logic [PRESC_W-1:0] pc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   duty_sh;
  logic [CNT_W-1:0]   period_sh;

  logic hit, acc, wr;
  logic sel_duty, sel_per, sel_ctrl, sel_stat;
  logic [31:0] rd_v;
  logic [31:0] wr_v;
  logic unused;

  assign unused = ^mem_addr[1:0];

  assign hit = mem_valid &&
               (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign acc = hit && !mem_ready;
  assign wr  = acc && (|mem_wstrb);

  assign sel_duty = (mem_addr[3:2] == 2'd0);
  assign sel_per  = (mem_addr[3:2] == 2'd1);
  assign sel_ctrl = (mem_addr[3:2] == 2'd2);
  assign sel_stat = (mem_addr[3:2] == 2'd3);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    rd_v = '0;
    unique case (1'b1)
      sel_duty: rd_v = 32'(duty_q);
      sel_per:  rd_v = 32'(period_q);
      sel_ctrl: begin
        rd_v[0]            = en_q;
        rd_v[8 +: PRESC_W] = presc_q;
      end
      sel_stat: begin
        rd_v[CNT_W-1:0] = cnt;
        rd_v[31]        = pwm_out;
      end
      default: rd_v = '0;
    endcase
  end

  // Read-modify-write of the selected register, lane by lane.
  assign wr_v = merge(rd_v, mem_wdata, mem_wstrb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      duty_q    <= '0;
      period_q  <= CNT_W'(9);
      en_q      <= 1'b1;
      presc_q   <= '0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_v : '0;
      if (wr) begin
        unique case (1'b1)
          sel_duty: duty_q   <= wr_v[CNT_W-1:0];
          sel_per:  period_q <= wr_v[CNT_W-1:0];
          sel_ctrl: begin
            en_q    <= wr_v[0];
            presc_q <= wr_v[8 +: PRESC_W];
          end
          default: ;
        endcase
      end
    end
  end

  // Shadows only reload at a wrap (or while idle), so
  // cnt can never run past period_sh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= '0;
      cnt          <= '0;
      duty_sh      <= '0;
      period_sh    <= CNT_W'(9);
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (!en_q) begin
      pc           <= '0;
      cnt          <= '0;
      duty_sh      <= duty_q;
      period_sh    <= period_q;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      pwm_out      <= (cnt < duty_sh);
      if (pc > presc_q) begin
        // PRESC shrank below pc: resync without a tick.
        pc <= '0;
      end else if (pc == presc_q) begin
        pc <= '0;
        if (cnt == period_sh) begin
          cnt          <= '0;
          period_start <= 1'b1;
          duty_sh      <= duty_q;
          period_sh    <= period_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_pwm.sv
// tb_mmio_pwm: self-checking bench for mmio_pwm.
// Waveforms are checked against period/high-time arithmetic.
module tb_mmio_pwm;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        pwm_out;
  logic        period_start;

  mmio_pwm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit pwm_h [HN];
  bit ps_h  [HN];

  logic [31:0] m_duty, m_period, m_ctrl;

  always @(negedge clk) begin
    if (cyc < HN) begin
      pwm_h[cyc] = pwm_out;
      ps_h[cyc]  = period_start;
    end
    cyc++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd);
    int lat;
    bit got;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = be;
    lat = 0;
    got = 0;
    rd  = '0;
    while (!got && lat < 10) begin
      step();
      lat++;
      if (mem_ready) begin
        got = 1;
        rd  = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    chk("ack_latency", lat, 1);
    step();
    chk("idle_ready", {31'b0, mem_ready}, 0);
    chk("idle_rdata", mem_rdata, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    logic [31:0] r;
    bus(a, d, be, r);
    case (a[3:2])
      2'd0: m_duty   = merge(m_duty, d, be) & 32'h0000_FFFF;
      2'd1: m_period = merge(m_period, d, be) & 32'h0000_FFFF;
      2'd2: m_ctrl   = merge(m_ctrl, d, be) & 32'h0000_FF01;
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 32'h0, 4'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_ps(output int idx);
    int n;
    n = 0;
    idx = -1;
    while (n < 2000) begin
      step();
      n++;
      if (period_start) begin
        idx = cyc;
        break;
      end
    end
    chk("ps_seen", {31'b0, period_start}, 1);
  endtask

  // Expected pwm at offset t from a period_start: high for the first
  // H cycles of each period, seen one cycle late.
  task automatic check_wave(input string tag, input int s, input int d,
                            input int p, input int pr, input int nper);
    int l, h, bad;
    bit ep, es;
    l = (p + 1) * (pr + 1);
    h = ((d < p + 1) ? d : p + 1) * (pr + 1);
    bad = 0;
    while (cyc <= s + nper * l) step();
    for (int t = 0; t < nper * l; t++) begin
      ep = (((t + l - 1) % l) < h);
      es = ((t % l) == 0);
      if (s < 0 || s + t >= HN) bad++;
      else if (pwm_h[s+t] !== ep || ps_h[s+t] !== es) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic run_wave(input string tag, input int d, input int p,
                          input int pr, input int nper);
    int s;
    wr(BASE + 32'h0, d, 4'hF);
    wr(BASE + 32'h4, p, 4'hF);
    wr(BASE + 32'h8, (pr << 8) | 1, 4'hF);
    wait_ps(s);
    wait_ps(s);
    check_wave(tag, s, d, p, pr, nper);
  endtask

  initial begin
    int s, n, hi0, hi1, rdy;
    logic [31:0] d32;
    logic [3:0] be;

    m_duty = 0;
    m_period = 9;
    m_ctrl = 1;
    repeat (3) step();
    chk("rst_ready", {31'b0, mem_ready}, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_pwm", {31'b0, pwm_out}, 0);
    chk("rst_ps", {31'b0, period_start}, 0);
    rst_n = 1'b1;

    rd_chk("rd_duty", BASE + 32'h0, 32'h0);
    rd_chk("rd_period", BASE + 32'h4, 32'h9);
    rd_chk("rd_ctrl", BASE + 32'h8, 32'h1);

    // Held request: ack, gap, ack, gap, ack.
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h8;
    mem_wstrb = 4'h0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("held_ready", {31'b0, mem_ready}, (i % 2));
      chk("held_rdata", mem_rdata, (i % 2) ? m_ctrl : 32'h0);
    end
    mem_valid = 1'b0;
    step();
    step();

    run_wave("wave_d3p9", 3, 9, 0, 2);

    // DUTY changed mid-period only applies from the next period.
    wait_ps(s);
    step();
    wr(BASE + 32'h0, 32'd7, 4'hF);
    while (cyc <= s + 21) step();
    hi0 = 0;
    hi1 = 0;
    for (int t = 1; t <= 10; t++) hi0 += pwm_h[s+t];
    for (int t = 11; t <= 20; t++) hi1 += pwm_h[s+t];
    chk("mid_old_high", hi0, 3);
    chk("mid_new_high", hi1, 7);

    run_wave("wave_d0", 0, 9, 0, 2);
    run_wave("wave_d10", 10, 9, 0, 2);
    run_wave("wave_presc2", 3, 9, 2, 2);

    for (int k = 0; k < 6; k++)
      run_wave("wave_rand", $urandom_range(0, 12),
               $urandom_range(0, 10), $urandom_range(0, 3), 2);

    // Disable: output low, counter parked at 0.
    wr(BASE + 32'h8, 32'h0, 4'hF);
    step();
    chk("dis_pwm", {31'b0, pwm_out}, 0);
    rd_chk("dis_status", BASE + 32'hC, 32'h0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd_chk("stat_ro", BASE + 32'hC, 32'h0);

    // Miss: never acknowledged.
    mem_valid = 1'b1;
    mem_addr  = 32'h2000_0000;
    mem_wstrb = 4'hF;
    rdy = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      rdy += mem_ready;
      n += period_start + pwm_out;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    chk("miss_ready", rdy, 0);
    chk("dis_quiet", n, 0);

    wr(BASE + 32'h4, 32'h9, 4'hF);
    wr(BASE + 32'h4, 32'hABCD_1234, 4'b0001);
    rd_chk("strb_period", BASE + 32'h4, m_period);
    for (int k = 0; k < 4; k++) begin
      d32 = $urandom;
      be  = 4'($urandom_range(0, 15));
      wr(BASE + 32'h0, d32, be);
      rd_chk("strb_duty", BASE + 32'h0, m_duty);
    end

    run_wave("wave_reen", 3, 9, 0, 1);

    // Reset during a write and mid-period.
    wait_ps(s);
    repeat (4) step();
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h0;
    mem_wdata = 32'd5;
    mem_wstrb = 4'hF;
    rst_n = 1'b0;
    step();
    chk("rst2_ready", {31'b0, mem_ready}, 0);
    chk("rst2_pwm", {31'b0, pwm_out}, 0);
    chk("rst2_ps", {31'b0, period_start}, 0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    rst_n = 1'b1;
    m_duty = 0;
    m_period = 9;
    m_ctrl = 1;
    n = 0;
    while (n < 40 && !period_start) begin
      step();
      n++;
    end
    chk("rst2_first_period", n, 10);
    rd_chk("rst2_duty", BASE + 32'h0, m_duty);
    rd_chk("rst2_period", BASE + 32'h4, m_period);
    rd_chk("rst2_ctrl", BASE + 32'h8, m_ctrl);
    wait_ps(s);
    wait_ps(s);
    check_wave("wave_after_rst", s, 0, 9, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
